// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer
//
// Sink end of the rasterizer pixel stream. Each cycle an incoming pixel is
// clipped against the screen. An on-screen pixel is turned into a linear
// framebuffer address, packed with its colour and pushed into a small FIFO.
// A two-state write engine drains the FIFO into the SRAM controller through
// a req/ack handshake.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   n_rst        asynchronous active-low reset
//   pixel_valid  X/Y/r_i/g_i/b_i carry a pixel this cycle
//   X, Y         pixel column / row
//   r_i,g_i,b_i  pixel colour channels
//   clear        synchronous clear of overflow and pixel_count
//   mem_ack      memory accepted the current write
//   mem_wr_req   write request, held until acked
//   mem_addr     Y*WIDTH + X of the pixel being written
//   mem_data     {r, g, b}, with r in the MSBs
//   idle         FIFO empty and no request outstanding
//   overflow     sticky, set when an on-screen pixel was dropped
//   pixel_count  number of acked writes, wraps modulo 2^16

module gpu_pixel_writer #(
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8,
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int ADDR_BITS    = 19,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      pixel_valid,
   input  logic [WIDTH_BITS-1:0]     X,
   input  logic [HEIGHT_BITS-1:0]    Y,
   input  logic [CHANNEL_BITS-1:0]   r_i,
   input  logic [CHANNEL_BITS-1:0]   g_i,
   input  logic [CHANNEL_BITS-1:0]   b_i,
   input  logic                      clear,
   input  logic                      mem_ack,
   output logic                      mem_wr_req,
   output logic [ADDR_BITS-1:0]      mem_addr,
   output logic [3*CHANNEL_BITS-1:0] mem_data,
   output logic                      idle,
   output logic                      overflow,
   output logic [15:0]               pixel_count
);

   localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
   localparam int DATA_BITS = 3*CHANNEL_BITS;

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t state;
   state_t next_state;

   logic [ADDR_BITS-1:0]  fifo_addr [FIFO_DEPTH];
   logic [DATA_BITS-1:0]  fifo_data [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr;
   logic [PTR_BITS-1:0]   rd_ptr;
   logic [PTR_BITS:0]     fifo_count;

   logic                  on_screen;
   logic                  accept;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic                  write_done;
   logic [ADDR_BITS-1:0]  push_addr;
   logic [DATA_BITS-1:0]  push_data;

   // Widen coordinates to 32 bits so the bound test also works when WIDTH or
   // HEIGHT equals 2^WIDTH_BITS / 2^HEIGHT_BITS.
   assign on_screen = (32'(X) < 32'(WIDTH)) && (32'(Y) < 32'(HEIGHT));
   assign accept    = pixel_valid && on_screen;

   assign push_addr = ADDR_BITS'(32'(Y) * 32'(WIDTH) + 32'(X));
   assign push_data = {r_i, g_i, b_i};

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (PTR_BITS+1)'(FIFO_DEPTH));

   // A write completes when the memory acks an outstanding request.
   assign write_done = (state == ST_REQ) && mem_ack;

   // The head is popped into the output register whenever the engine is free
   // (idle, or just acked). The pop only looks at the count before this edge,
   // so a pixel pushed into an empty FIFO is popped one edge later.
   assign pop  = !fifo_empty && ((state == ST_IDLE) || write_done);

   // A full FIFO can still take a pixel when the head leaves at the same edge.
   assign push = accept && (!fifo_full || pop);
   assign drop = accept && !push;

   // Write engine state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: stay in REQ back-to-back while there is more to write.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (!fifo_empty) next_state = ST_REQ;
         ST_REQ:  if (mem_ack && fifo_empty) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Output logic of the write engine.
   always_comb begin
      mem_wr_req = (state == ST_REQ);
      idle       = (state == ST_IDLE) && fifo_empty;
   end

   // Output register: loads the FIFO head on pop and otherwise holds, which
   // keeps address and data stable while a request waits for its ack.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mem_addr <= '0;
         mem_data <= '0;
      end else if (pop) begin
         mem_addr <= fifo_addr[rd_ptr];
         mem_data <= fifo_data[rd_ptr];
      end
   end

   // FIFO storage has no reset; emptiness is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= push_addr;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Status: clear takes priority over a coinciding ack or drop.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         overflow    <= 1'b0;
         pixel_count <= '0;
      end else if (clear) begin
         overflow    <= 1'b0;
         pixel_count <= '0;
      end else begin
         if (drop)       overflow    <= 1'b1;
         if (write_done) pixel_count <= pixel_count + 16'd1;
      end
   end

endmodule
